// File: rtl/ser_pkg.sv
// -----------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the bit serializer slice.
//   SER_WIDTH   : default parallel word width
//   ser_state_t : serializer FSM encoding (S_IDLE = 1'b0, S_SHIFT = 1'b1)
// No ports (package).
// -----------------------------------------------------------------------------
package ser_pkg;

   localparam int SER_WIDTH = 8;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/ser_hold_buf.sv
// -----------------------------------------------------------------------------
// ser_hold_buf
// One-entry holding register with a full flag. Parks the next word while the
// serializer is still shifting out the current one.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (empties the buffer)
//   wr_en : write d into the buffer, sets full
//   rd_en : the buffer contents are consumed this edge, clears full
//   d     : word to park
//   q     : parked word
//   full  : buffer holds a word
// -----------------------------------------------------------------------------
module ser_hold_buf
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             full
);

   // A write only happens while empty and a read only while full, so the two
   // never collide; write still takes priority to keep the intent explicit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= '0;
         full <= 1'b0;
      end else if (wr_en) begin
         q    <= d;
         full <= 1'b1;
      end else if (rd_en) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial converter feeding a downstream run detector. A word is
// loaded straight into the shifter when idle; a word arriving while shifting
// is parked in ser_hold_buf and transferred on the last-bit edge so that
// consecutive words stream out with no gap.
//
// Handshake: a word transfers on every rising edge where in_valid and
// in_ready are both 1. in_ready is a function of registered state only
// (the holding register is empty); it never depends on in_valid.
//
// Build option: define SER_LSB_FIRST_EN to emit data_in[0] first; the
// default build emits data_in[WIDTH-1] first. Timing is identical.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   data_in   : parallel word (WIDTH bits)
//   in_valid  : data_in is valid
//   in_ready  : a word can be accepted
//   x         : serial bit, 0 when idle
//   x_valid   : x carries a data bit this cycle
//   busy      : shifter or holding register occupied
//   word_done : last bit of the current word is on x
//   dbg_state : current FSM state (ser_state_t encoding) for observation
// -----------------------------------------------------------------------------
module bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             word_done,
   output logic             dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ser_state_t       state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx, shreg_shifted;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             out_bit;
   logic             accept;
   logic             hold_wr, hold_rd, hold_full;
   logic [WIDTH-1:0] hold_q;

   assign in_ready = ~hold_full;
   assign accept   = in_valid & in_ready;

`ifdef SER_LSB_FIRST_EN
   assign out_bit       = shreg[0];
   assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
`else
   assign out_bit       = shreg[WIDTH-1];
   assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
`endif

   ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .wr_en (hold_wr),
      .rd_en (hold_rd),
      .d     (data_in),
      .q     (hold_q),
      .full  (hold_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         shreg <= shreg_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      cnt_nx   = cnt;
      hold_wr  = 1'b0;
      hold_rd  = 1'b0;
      if (state == S_IDLE) begin
         if (accept) begin
            shreg_nx = data_in;
            cnt_nx   = '0;
            state_nx = S_SHIFT;
         end
      end else begin
         if (cnt != CNT_LAST) begin
            shreg_nx = shreg_shifted;
            cnt_nx   = cnt + CW'(1);
            hold_wr  = accept;
         end else if (hold_full) begin
            // Parked word wins over the input; in_ready is 0 here anyway.
            shreg_nx = hold_q;
            cnt_nx   = '0;
            hold_rd  = 1'b1;
         end else if (accept) begin
            shreg_nx = data_in;
            cnt_nx   = '0;
         end else begin
            // Clear the shifter so nothing stale is left for the next word.
            shreg_nx = '0;
            cnt_nx   = '0;
            state_nx = S_IDLE;
         end
      end
   end

   assign x_valid   = (state == S_SHIFT);
   assign x         = x_valid & out_bit;
   assign word_done = x_valid & (cnt == CNT_LAST);
   assign busy      = x_valid | hold_full;
   assign dbg_state = state;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] data_in;
   logic         in_valid;
   logic         in_ready;
   logic         x;
   logic         x_valid;
   logic         busy;
   logic         word_done;
   logic         dbg_state;

   int checks = 0;
   int errors = 0;

   // scoreboard entry: {expected bit, expected word_done}
   logic [1:0] exp_q[$];

   bit_serializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .x_valid   (x_valid),
      .busy      (busy),
      .word_done (word_done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // i-th transmitted bit of word w, in transmission order
   function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef SER_LSB_FIRST_EN
      return w[i];
`else
      return w[W-1-i];
`endif
   endfunction

   // ---------------- scoreboard: push on accept ----------------
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
         for (int i = 0; i < W; i++)
            exp_q.push_back({exp_bit(data_in, i), 1'(i == W - 1)});
      end
   end

   // ---------------- scoreboard: pop / compare ----------------
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst === 1'b1) begin
         exp_q.delete();
         checks++;
         if (x_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
             word_done !== 1'b0 || x !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: x=%b x_valid=%b busy=%b in_ready=%b word_done=%b, want 0 0 0 1 0",
                     x, x_valid, busy, in_ready, word_done);
         end
      end else if (rst === 1'b0) begin
         checks++;
         if (x_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL sb_x_valid at %0t: got %b want %b (queued %0d)",
                     $time, x_valid, exp_q.size() != 0, exp_q.size());
         end
         checks++;
         if (busy !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL sb_busy at %0t: got %b want %b", $time, busy, exp_q.size() != 0);
         end
         checks++;
         if (in_ready !== (exp_q.size() <= W)) begin
            errors++;
            $display("FAIL sb_in_ready at %0t: got %b want %b (queued %0d)",
                     $time, in_ready, exp_q.size() <= W, exp_q.size());
         end
         if (exp_q.size() != 0 && x_valid === 1'b1) begin
            e = exp_q.pop_front();
            checks++;
            if (x !== e[1] || word_done !== e[0]) begin
               errors++;
               $display("FAIL sb_bit at %0t: x=%b word_done=%b want x=%b word_done=%b",
                        $time, x, word_done, e[1], e[0]);
            end
         end else begin
            checks++;
            if (x !== 1'b0 || word_done !== 1'b0) begin
               errors++;
               $display("FAIL sb_idle_outputs at %0t: x=%b word_done=%b want 0 0",
                        $time, x, word_done);
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy !== 1'b0 || x_valid !== 1'b0) && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0 || x_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: busy=%b x_valid=%b after %0d cycles, want idle", name, busy, x_valid, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      data_in = 8'hFF;
      repeat (3) tick();
      checks++;
      if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0 ||
          in_ready !== 1'b1 || dbg_state !== ser_pkg::S_IDLE) begin
         errors++;
         $display("FAIL reset_state: x=%b x_valid=%b busy=%b word_done=%b in_ready=%b state=%b want 0 0 0 0 1 0",
                  x, x_valid, busy, word_done, in_ready, dbg_state);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      checks++;
      if (x_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_accept: x_valid=%b busy=%b want 0 0", x_valid, busy);
      end
   endtask

   task automatic test_single_word();
      logic [7:0] pat;
      pat = 8'hA5;  // same order in both builds
      in_valid = 1'b1;
      data_in = 8'hA5;
      tick();
      in_valid = 1'b0;
      data_in = W'($urandom);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (x_valid !== 1'b1 || x !== pat[7-i] || word_done !== 1'(i == 7)) begin
            errors++;
            $display("FAIL single_bit%0d: x_valid=%b x=%b word_done=%b want 1 %b %b",
                     i, x_valid, x, word_done, pat[7-i], i == 7);
         end
         tick();
      end
      checks++;
      if (x_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_end: x_valid=%b busy=%b want 0 0", x_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      data_in = 8'hFF;
      tick();
      for (int i = 0; i < 16; i++) begin
         if (i == 0) data_in = 8'h00;
         if (i == 1) in_valid = 1'b0;
         checks++;
         if (x_valid !== 1'b1 || x !== 1'(i < 8) || in_ready !== 1'(i == 0 || i >= 8)) begin
            errors++;
            $display("FAIL b2b_cycle%0d: x_valid=%b x=%b in_ready=%b want 1 %b %b",
                     i, x_valid, x, in_ready, i < 8, i == 0 || i >= 8);
         end
         tick();
      end
      checks++;
      if (x_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: x_valid=%b want 0", x_valid);
      end
   endtask

   task automatic test_third_word();
      logic exp_x;
      in_valid = 1'b1;
      data_in = 8'hFF;
      tick();
      for (int i = 0; i < 24; i++) begin
         if (i == 0) data_in = 8'h00;
         if (i == 1) data_in = 8'h3C;
         if (i == 9) in_valid = 1'b0;
         exp_x = (i < 8) ? 1'b1 : (i < 16) ? 1'b0 : exp_bit(8'h3C, i - 16);
         checks++;
         if (x_valid !== 1'b1 || x !== exp_x ||
             in_ready !== 1'(i == 0 || i == 8 || i >= 16)) begin
            errors++;
            $display("FAIL third_cycle%0d: x_valid=%b x=%b in_ready=%b want 1 %b %b",
                     i, x_valid, x, in_ready, exp_x, i == 0 || i == 8 || i >= 16);
         end
         tick();
      end
      checks++;
      if (x_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL third_end: x_valid=%b busy=%b want 0 0", x_valid, busy);
      end
   endtask

   task automatic test_reset_mid_word();
      in_valid = 1'b1;
      data_in = 8'hF0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) data_in = 8'h0F;
         if (i == 1) in_valid = 1'b0;
         checks++;
         if (x_valid !== 1'b1 || x !== exp_bit(8'hF0, i)) begin
            errors++;
            $display("FAIL rstmid_bit%0d: x_valid=%b x=%b want 1 %b", i, x_valid, x, exp_bit(8'hF0, i));
         end
         if (i < 3) tick();
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_held: busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (x_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || x !== 1'b0 || word_done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_immediate: x_valid=%b busy=%b in_ready=%b x=%b word_done=%b want 0 0 1 0 0",
                  x_valid, busy, in_ready, x, word_done);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (x_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after%0d: x_valid=%b busy=%b want 0 0", i, x_valid, busy);
         end
         tick();
      end
   endtask

   task automatic test_bit_order();
      logic [7:0] seq;  // bit 7 = first transmitted
`ifdef SER_LSB_FIRST_EN
      seq = 8'b1000_0000;
`else
      seq = 8'b0000_0001;
`endif
      in_valid = 1'b1;
      data_in = 8'h01;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (x_valid !== 1'b1 || x !== seq[7-i]) begin
            errors++;
            $display("FAIL order_bit%0d: x_valid=%b x=%b want 1 %b", i, x_valid, x, seq[7-i]);
         end
         tick();
      end
      wait_idle("order");
   endtask

   task automatic test_detector();
      logic [7:0] y_exp;  // bit 7 = first bit time
      logic       last_x;
      int         run;
      logic       y;
`ifdef SER_LSB_FIRST_EN
      y_exp = 8'h09;
`else
      y_exp = 8'h24;
`endif
      run = 0;
      last_x = 1'b0;
      in_valid = 1'b1;
      data_in = 8'hE3;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (x_valid === 1'b1) begin
            run = (run > 0 && x === last_x) ? run + 1 : 1;
            last_x = x;
         end
         y = (x_valid === 1'b1) && (run >= 3);
         checks++;
         if (y !== y_exp[7-i]) begin
            errors++;
            $display("FAIL detector_y%0d: y=%b want %b (x=%b)", i, y, y_exp[7-i], x);
         end
         tick();
      end
      wait_idle("detector");
   endtask

   task automatic test_random();
      int gap;
      int n;
      for (int k = 0; k < 40; k++) begin
         gap = $urandom_range(0, 3);
         if (k > 20) gap = 0;
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
         end
         in_valid = 1'b1;
         data_in = W'($urandom);
         n = 0;
         while (in_ready !== 1'b1 && n < 3 * W) begin
            tick();
            n++;
         end
         if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL random_accept_timeout word %0d: in_ready=%b want 1", k, in_ready);
         end
         tick();
      end
      in_valid = 1'b0;
      wait_idle("random");
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_leftover: %0d bits still expected, want 0", exp_q.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      data_in = '0;
      test_reset();
      test_single_word();
      tick();
      test_back_to_back();
      tick();
      test_third_word();
      tick();
      test_reset_mid_word();
      test_bit_order();
      tick();
      test_detector();
      tick();
      test_random();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have input `clk`, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input `rst`, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have input `data_in`, WIDTH bits: parallel word to serialize.
REQ-005 SHALL have input `in_valid`, 1 bit: `data_in` is valid.
REQ-006 SHALL have output `in_ready`, 1 bit: a word is accepted on any edge where `in_valid` and `in_ready` are both 1.
REQ-007 SHALL have output `x`, 1 bit: serial bit stream for the downstream run-detector input.
REQ-008 SHALL have output `x_valid`, 1 bit: `x` carries a data bit this cycle.
REQ-009 SHALL have output `busy`, 1 bit: the shifter or the holding register is occupied.
REQ-010 SHALL have output `word_done`, 1 bit: high during the cycle the last bit of a word is on `x`.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-012 SHALL contain a WIDTH-bit shift register, a bit counter of $clog2(WIDTH) bits, and a one-entry holding register with a full flag.
REQ-013 SHALL drive `in_ready` = NOT hold_full, derived from registered state only, with no combinational path from `in_valid`.
REQ-014 In IDLE, an accepted word SHALL load directly into the shifter, with counter=0 and next state SHIFT.
REQ-015 The first bit SHALL appear on `x` in the cycle after the accept edge, giving a latency of 1 cycle.
REQ-016 In SHIFT, `x_valid`=1, `x` = current output bit, and the counter SHALL increment on each edge.
REQ-017 In SHIFT, a word accepted before the last bit SHALL be written to the holding register, setting hold_full.
REQ-018 At the edge ending the last bit (counter=WIDTH-1), priority SHALL be:
- hold_full: transfer hold to the shifter, clear hold_full, stay in SHIFT.
- else, accept on the same edge: load `data_in` directly, stay in SHIFT.
- else: go to IDLE.
REQ-019 Back-to-back words SHALL be emitted with no gap cycle on `x_valid`.
REQ-020 `word_done` SHALL be SHIFT AND counter=WIDTH-1.
REQ-021 `busy` SHALL be (state==SHIFT) OR hold_full.
REQ-022 In IDLE, `x` SHALL be 0 and `x_valid` SHALL be 0.
REQ-023 SHALL transmit MSB first by default.

Reset
REQ-024 On `rst`=1, the block SHALL immediately enter IDLE, clear the shifter, counter and hold_full, and drive `x`=0, `x_valid`=0, `busy`=0, `word_done`=0, `in_ready`=1.
REQ-025 Reset mid-word SHALL discard both the in-flight word and the held word; no partial bits SHALL appear after reset.
REQ-026 SHALL accept no word while `rst`=1.

Configuration
REQ-027 Macro SER_LSB_FIRST_EN defined: bits SHALL be emitted LSB first (data_in[0] first).
REQ-028 Macro SER_LSB_FIRST_EN undefined: bits SHALL be emitted MSB first (data_in[WIDTH-1] first).
REQ-029 Handshake, latency and timing SHALL be identical in both builds.

Structure
REQ-030 A shared package `ser_pkg` SHALL hold the state encoding constants S_IDLE=1'b0 and S_SHIFT=1'b1, and the default width constant SER_WIDTH=8.
REQ-031 The holding register plus full flag SHALL be one sub-module, `ser_hold_buf`, with ports clk, rst, wr_en, rd_en, d, q and full.
REQ-032 The FSM, shifter and counter SHALL reside in `bit_serializer`.

Verification
REQ-033 After reset, send 8'hA5 for 1 cycle in IDLE -> next 8 cycles: x=1,0,1,0,0,1,0,1, x_valid=1, word_done only in the 8th cycle; then x_valid=0.
REQ-034 Hold in_valid with 8'hFF then 8'h00 -> 16 contiguous x_valid cycles carrying 8 ones then 8 zeros; in_ready=0 from the cycle after the 2nd accept until the transfer edge.
REQ-035 Present a 3rd word while hold_full -> in_ready=0, word not lost while in_valid held; it is accepted in the cycle after the transfer and emitted immediately after word 2, with no gap.
REQ-036 Assert rst during bit 4 of 8'hF0 with a held word -> same cycle: x_valid=0, busy=0, in_ready=1; no further bits emitted.
REQ-037 Build with SER_LSB_FIRST_EN, send 8'h01 -> x=1,0,0,0,0,0,0,0.
REQ-038 Send 8'hE3 into the downstream three-in-a-row detector -> detector output y=1 on the 3rd '1' and the 3rd '0'.
